// File: rtl/mac_acc34_if.sv
// ============================================================================
// mac_acc34_if : operand stream and result bus of the signed MAC stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface mac_acc34_if #(
  parameter int DW = 16,
  parameter int AW = 34,
  parameter int CW = 8
);
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          valid;
  logic          first;
  logic          last;
  logic [AW-1:0] acc;
  logic          done;
  logic          busy;
  logic          ovf;
  logic [CW-1:0] cnt;

  // master: operand producer / result consumer
  modport master (
    output a, b, valid, first, last,
    input  acc, done, busy, ovf, cnt
  );

  // slave: the MAC stage itself
  modport slave (
    input  a, b, valid, first, last,
    output acc, done, busy, ovf, cnt
  );
endinterface

`default_nettype wire

// File: rtl/mac_acc34.sv
// ============================================================================
// mac_acc34 : two-stage signed multiply-accumulate with a saturating
//             accumulator, First/Last framing and a one-cycle Done strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module mac_acc34 #(
  parameter int DW = 16,
  parameter int AW = 34,
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mac_acc34_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [AW-1:0] c_acc_max = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] c_acc_min = {1'b1, {(AW-1){1'b0}}};
  localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  // ---------------------------------------------------------------- stage 1
  logic signed [2*DW-1:0] w_prod_full;
  logic        [AW-1:0]   w_prod_ext;
  logic        [AW-1:0]   r_prod;
  logic                   r_pv;
  logic                   r_pf;
  logic                   r_pl;

  // operands widened first so the low 2*DW bits hold the exact product
  assign w_prod_full = $signed({{DW{bus.a[DW-1]}}, bus.a})
                     * $signed({{DW{bus.b[DW-1]}}, bus.b});
  assign w_prod_ext  = {{(AW-2*DW){w_prod_full[2*DW-1]}}, w_prod_full};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_pv   <= 1'b0;
      r_pf   <= 1'b0;
      r_pl   <= 1'b0;
    end else begin
      r_pv <= bus.valid;
      if (bus.valid) begin
        r_prod <= w_prod_ext;
        r_pf   <= bus.first;
        r_pl   <= bus.last;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_acc_nxt;
  logic          r_ovf;
  logic          w_ovf_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_done;
  logic          w_done_nxt;

  logic [AW:0]   w_sum;
  logic          w_pos_clip;
  logic          w_neg_clip;
  logic [AW-1:0] w_acc_sat;
  logic [CW-1:0] w_cnt_inc;

  // one guard bit is enough: both addends fit in AW bits
  assign w_sum      = {r_acc[AW-1], r_acc} + {r_prod[AW-1], r_prod};
  assign w_pos_clip = ~w_sum[AW] &  w_sum[AW-1];
  assign w_neg_clip =  w_sum[AW] & ~w_sum[AW-1];
  assign w_acc_sat  = w_pos_clip ? c_acc_max :
                      w_neg_clip ? c_acc_min : w_sum[AW-1:0];
  assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE, S_HOLD: begin
        if (r_pv && r_pf) begin
          w_acc_nxt   = r_prod;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = c_cnt_one;
          w_state_nxt = r_pl ? S_HOLD : S_ACCUM;
          w_done_nxt  = r_pl;
        end
      end
      S_ACCUM: begin
        if (r_pv) begin
          // a First inside a vector silently restarts it
          if (r_pf) begin
            w_acc_nxt = r_prod;
            w_ovf_nxt = 1'b0;
            w_cnt_nxt = c_cnt_one;
          end else begin
            w_acc_nxt = w_acc_sat;
            w_ovf_nxt = r_ovf | w_pos_clip | w_neg_clip;
            w_cnt_nxt = w_cnt_inc;
          end
          w_state_nxt = r_pl ? S_HOLD : S_ACCUM;
          w_done_nxt  = r_pl;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_ovf  <= w_ovf_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign bus.acc  = r_acc;
  assign bus.ovf  = r_ovf;
  assign bus.cnt  = r_cnt;
  assign bus.done = r_done;
  assign bus.busy = (r_state == S_ACCUM);

endmodule

`default_nettype wire

// File: tb/tb_mac_acc34.sv
// ============================================================================
// tb_mac_acc34 : scoreboard bench for mac_acc34
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mac_acc34;

  localparam longint c_max = 64'sd8589934591;
  localparam longint c_min = -64'sd8589934592;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_acc34_if #(.DW(16), .AW(34), .CW(8)) bus ();

  mac_acc34 #(.DW(16), .AW(34), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    longint acc;
    longint cnt;
    longint ovf;
    longint cyc;
  } sb_t;

  sb_t    sb[$];
  sb_t    mon_e;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  // reference model state
  longint m_acc = 0;
  longint m_cnt = 0;
  longint m_ovf = 0;
  bit     m_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid = 1'b0;
      bus.first = 1'b0;
      bus.last  = 1'b0;
    end
  endtask

  // drive one pair; the model decides whether a result is expected
  task automatic term(input int a, input int b, input bit f, input bit l);
    longint p;
    @(negedge clk);
    bus.a     = 16'(a);
    bus.b     = 16'(b);
    bus.valid = 1'b1;
    bus.first = f;
    bus.last  = l;
    p = longint'(a) * longint'(b);
    if (f) begin
      m_acc = p; m_cnt = 1; m_ovf = 0; m_active = 1'b1;
    end else if (m_active) begin
      m_acc = m_acc + p;
      if (m_acc > c_max) begin m_acc = c_max; m_ovf = 1; end
      if (m_acc < c_min) begin m_acc = c_min; m_ovf = 1; end
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
    if (l && m_active) begin
      sb.push_back('{acc: m_acc, cnt: m_cnt, ovf: m_ovf, cyc: cyc + 2});
      m_active = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cyc", cyc, mon_e.cyc);
        chk("done_acc", $signed(bus.acc), mon_e.acc);
        chk("done_cnt", longint'(bus.cnt), mon_e.cnt);
        chk("done_ovf", longint'(bus.ovf), mon_e.ovf);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missed_done", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    bus.a = '0; bus.b = '0; bus.valid = 1'b0; bus.first = 1'b0; bus.last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acc", $signed(bus.acc), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_ovf", longint'(bus.ovf), 0);
    chk("rst_cnt", longint'(bus.cnt), 0);
    rst_n = 1'b1;

    // non-First term in IDLE is ignored
    term(9, 9, 0, 1);
    idle(3);
    chk("idle_ignore_acc", $signed(bus.acc), 0);

    // basic dot product
    term(3, 4, 1, 0);
    term(-5, 6, 0, 0);
    term(7, -8, 0, 1);
    chk("busy_accum", longint'(bus.busy), 1);
    idle(3);
    chk("basic_acc", $signed(bus.acc), -74);
    chk("basic_busy_after", longint'(bus.busy), 0);

    // bubbles
    term(3, 4, 1, 0); idle(2);
    term(-5, 6, 0, 0); idle(2);
    term(7, -8, 0, 1); idle(3);
    chk("bubble_acc", $signed(bus.acc), -74);

    // single-term vector
    term(-32768, -32767, 1, 1);
    idle(3);
    chk("single_acc", $signed(bus.acc), 64'sd1073709056);

    // positive saturation: clamps on the 8th term
    for (int k = 1; k <= 9; k++) term(-32768, -32768, k == 1, k == 9);
    chk("psat_7terms", $signed(bus.acc), 64'sd7516192768);
    chk("psat_7ovf", longint'(bus.ovf), 0);
    idle(1);
    chk("psat_8terms", $signed(bus.acc), c_max);
    chk("psat_8ovf", longint'(bus.ovf), 1);
    idle(3);
    chk("psat_final", $signed(bus.acc), c_max);

    // negative saturation: clamps only on the 9th term
    for (int k = 1; k <= 9; k++) term(-32768, 32767, k == 1, k == 9);
    idle(1);
    chk("nsat_8terms", $signed(bus.acc), -64'sd8589672448);
    chk("nsat_8ovf", longint'(bus.ovf), 0);
    idle(3);
    chk("nsat_final", $signed(bus.acc), c_min);
    chk("nsat_hold_ovf", longint'(bus.ovf), 1);

    // abort: a second First restarts the vector and clears Ovf
    term(10, 10, 1, 0);
    term(2, 3, 1, 0);
    term(1, 1, 0, 1);
    chk("abort_first_acc", $signed(bus.acc), 100);
    chk("abort_ovf_clr", longint'(bus.ovf), 0);
    idle(3);
    chk("abort_acc", $signed(bus.acc), 7);

    // non-First terms in HOLD are ignored
    term(5, 5, 0, 0);
    term(5, 5, 0, 1);
    idle(3);
    chk("hold_ignore_acc", $signed(bus.acc), 7);
    chk("hold_ignore_cnt", longint'(bus.cnt), 2);

    // back-to-back vectors
    term(1, 2, 1, 1);
    term(3, 3, 1, 0);
    term(1, 1, 0, 1);
    idle(4);
    chk("b2b_acc", $signed(bus.acc), 10);

    // term counter saturates at 255
    for (int k = 1; k <= 260; k++) term(1, 1, k == 1, k == 260);
    idle(3);
    chk("cnt_sat", longint'(bus.cnt), 255);

    // random vector with random bubbles
    for (int k = 1; k <= 40; k++) begin
      term(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
           k == 1, k == 40);
      if ($urandom_range(3) == 0) idle(1);
    end
    idle(4);

    // asynchronous reset mid-vector
    term(4, 5, 1, 0);
    term(6, 7, 0, 0);
    idle(2);
    chk("pre_rst_acc", $signed(bus.acc), 62);
    #2 rst_n = 1'b0;
    m_active = 1'b0;
    #1;
    chk("mid_rst_acc", $signed(bus.acc), 0);
    chk("mid_rst_busy", longint'(bus.busy), 0);
    chk("mid_rst_cnt", longint'(bus.cnt), 0);
    chk("mid_rst_ovf", longint'(bus.ovf), 0);
    chk("mid_rst_done", longint'(bus.done), 0);
    idle(2);
    rst_n = 1'b1;
    term(8, 8, 0, 1);
    idle(3);
    chk("post_rst_ignore", $signed(bus.acc), 0);
    term(2, 2, 1, 0);
    term(3, 3, 0, 1);
    idle(3);
    chk("post_rst_acc", $signed(bus.acc), 13);

    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    if (sb.size() != 0) chk("sb_drain", longint'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
